// File: rtl/executs_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// The unit runs WIDTH shift-add or restoring-divide steps, then one sign-correction cycle before committing.
module executs_muldiv #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Md_op,
    input  logic [WIDTH-1:0] Operand_a,
    input  logic [WIDTH-1:0] Operand_b,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             Div_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, div_zero_reg;

    logic               launch, launch_iter, last_iter;
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub, div_rem;
    logic               div_ok;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   quo, rem, q_fix, r_fix, hi_fix, lo_fix;

    assign launch      = (state_reg == IDLE) && Start && !Flush;
    assign launch_iter = launch && !Md_op[2];
    assign last_iter   = (cnt_reg == CW'(WIDTH - 1));

    // Operands are latched as magnitudes; signs are reapplied in FIX.
    assign signed_op = (SIGNED_EN != 0) && !Md_op[0];
    assign a_neg     = signed_op && Operand_a[WIDTH-1];
    assign b_neg     = signed_op && Operand_b[WIDTH-1];
    assign a_mag     = a_neg ? -Operand_a : Operand_a;
    assign b_mag     = b_neg ? -Operand_b : Operand_b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);

    // Divide: acc = {remainder, dividend/quotient shift register}.
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
    assign div_rem   = div_ok ? div_sub : div_shift[WIDTH-1:0];

    assign acc_step = is_div_reg ? {div_rem, acc_reg[WIDTH-2:0], div_ok}
                                 : {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide-by-zero keeps the all-ones quotient; the remainder sign fix restores Operand_a.
    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quo      = acc_reg[WIDTH-1:0];
    assign rem      = acc_reg[2*WIDTH-1:WIDTH];
    assign q_fix    = dz_reg ? '1 : (neg_q_reg ? -quo : quo);
    assign r_fix    = neg_r_reg ? -rem : rem;
    assign hi_fix   = is_div_reg ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_fix   = is_div_reg ? q_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        Busy       = (state_reg != IDLE);
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (launch_iter) state_next = CALC;
                CALC:    if (last_iter) state_next = FIX;
                FIX:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;

            if (launch_iter) begin
                cnt_reg    <= '0;
                is_div_reg <= Md_op[1];
                dz_reg     <= Md_op[1] && (Operand_b == '0);
                neg_r_reg  <= Md_op[1] && a_neg;
                neg_q_reg  <= a_neg ^ b_neg;
                if (Md_op[1]) begin
                    acc_reg  <= {{WIDTH{1'b0}}, a_mag};
                    opnd_reg <= b_mag;
                end else begin
                    acc_reg  <= {{WIDTH{1'b0}}, b_mag};
                    opnd_reg <= a_mag;
                end
            end else if (launch && (Md_op[2:1] == 2'b10)) begin
                if (Md_op[0]) lo_reg <= Operand_a;
                else          hi_reg <= Operand_a;
            end

            if (state_reg == CALC && !Flush) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (state_reg == FIX && !Flush) begin
                hi_reg       <= hi_fix;
                lo_reg       <= lo_fix;
                done_reg     <= 1'b1;
                div_zero_reg <= is_div_reg && dz_reg;
            end
        end
    end

    assign Done     = done_reg;
    assign Div_zero = div_zero_reg;
    assign Hi       = hi_reg;
    assign Lo       = lo_reg;

endmodule
